// File: rtl/piso_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_serial_tx_pkg
// Brief   : Shared state encodings, line constants and sizing helper for the
//           parallel-in serial-out transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package piso_serial_tx_pkg;

    // Frame phases of the transmitter
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Level the serial line rests at between frames (also the stop-bit level)
    localparam logic c_LINE_IDLE = 1'b1;

    // Counter width for a count range of n values, never narrower than 1 bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : piso_serial_tx_pkg
`default_nettype wire

// File: rtl/piso_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : piso_serial_tx_bit_timer
// Brief   : Bit-period timer. Counts 0..BIT_CYCLES-1 while enabled and flags
//           the last cycle of every bit period. Also reports whether the
//           following cycle will be a last cycle, so the parent can register
//           its end-of-frame pulse.
// Revision: 1.0 - initial release
// ============================================================================
module piso_serial_tx_bit_timer
    import piso_serial_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick,
    output logic o_last_next
);

    localparam int             TW     = cnt_width(BIT_CYCLES);
    localparam logic [TW-1:0]  c_LAST = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;

    // Next count: clear wins, otherwise wrap to zero at the terminal count
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en) begin
            w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + TW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tick      = i_en && (r_cnt == c_LAST);
    assign o_last_next = (w_cnt_nxt == c_LAST);

endmodule : piso_serial_tx_bit_timer
`default_nettype wire

// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : piso_serial_tx
// Brief   : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over
//           a valid/ready handshake and shifts it out one bit per BIT_CYCLES
//           clocks, optionally framed by a start (0) and stop (1) bit.
//           Every output is registered; next-cycle values are derived from
//           the next state so the line changes right after the accept edge.
// Revision: 1.0 - initial release
// ============================================================================
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit START_STOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int            BW         = cnt_width(WIDTH);
    localparam logic [BW-1:0] c_BIT_LAST = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]    r_cnt;
    logic [BW-1:0]    w_cnt_nxt;

    logic             w_tick;
    logic             w_last_next;
    logic             w_ser_nxt;
    logic             w_done_nxt;

    logic             r_load_ready;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_busy;
    logic             r_done;

    // Timer runs during any frame phase and is held at zero while idle
    piso_serial_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_state != S_IDLE),
        .i_clr       (r_state == S_IDLE),
        .o_tick      (w_tick),
        .o_last_next (w_last_next)
    );

    // Next-state, shift register and bit counter, then next-cycle outputs
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_shift_nxt = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = START_STOP ? S_START : S_DATA;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_cnt == c_BIT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = START_STOP ? S_STOP : S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + BW'(1);
                        if (MSB_FIRST) begin
                            w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                        end else begin
                            w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level for the coming cycle; the active data bit sits at the
        // end of the shift register selected by the shift direction
        w_ser_nxt = c_LINE_IDLE;
        case (w_state_nxt)
            S_START: w_ser_nxt = 1'b0;
            S_DATA:  w_ser_nxt = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
            default: w_ser_nxt = c_LINE_IDLE;
        endcase

        // The coming cycle closes the frame when it is the last timer cycle
        // of the stop bit (framed) or of the final data bit (unframed)
        if (START_STOP) begin
            w_done_nxt = w_last_next && (w_state_nxt == S_STOP);
        end else begin
            w_done_nxt = w_last_next && (w_state_nxt == S_DATA) &&
                         (w_cnt_nxt == c_BIT_LAST);
        end
    end

    // State, datapath and registered outputs; reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_load_ready <= 1'b1;
            r_ser_out    <= c_LINE_IDLE;
            r_ser_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_load_ready <= (w_state_nxt == S_IDLE);
            r_ser_out    <= w_ser_nxt;
            r_ser_valid  <= (w_state_nxt == S_DATA);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= w_done_nxt;
        end
    end

    assign load_ready = r_load_ready;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : piso_serial_tx
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_serial_tx
// Brief   : Self-checking bench for piso_serial_tx. Three instances cover
//           MSB-first framed / LSB-first framed at 4 cycles per bit /
//           MSB-first unframed. Expected line activity comes from a frame
//           model built as a plain list of bit levels.
// Revision: 1.0 - initial release
// ============================================================================
module tb_piso_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din [3];
    logic       lv  [3];
    logic       lr  [3];
    logic       so  [3];
    logic       sv  [3];
    logic       bz  [3];
    logic       dn  [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    typedef struct {
        int          dut;
        logic [7:0]  word;
        logic [15:0] bits;
        int          nbits;
        bit          pulse;
    } vec_t;

    vec_t vecs [5];

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .START_STOP(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_in(din[0]), .load_valid(lv[0]), .load_ready(lr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .done(dn[0]));

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1'b0), .START_STOP(1'b1)) u_b (
        .clk(clk), .rst(rst), .data_in(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .done(dn[1]));

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .START_STOP(1'b0)) u_c (
        .clk(clk), .rst(rst), .data_in(din[2]), .load_valid(lv[2]), .load_ready(lr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bc_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    function automatic bit msb_of(input int d);
        return (d != 1);
    endfunction

    function automatic bit ss_of(input int d);
        return (d != 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a frame is start(0), the 8 data bits in send order, stop(1)
    task automatic model_bits(input int d, input logic [7:0] w);
        exp_q.delete();
        if (ss_of(d)) exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(msb_of(d) ? w[7-k] : w[k]);
        if (ss_of(d)) exp_q.push_back(1'b1);
    endtask

    // Hand-written frame string, first bit in the leftmost used position
    task automatic table_bits(input logic [15:0] s, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(s[n-1-k]);
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk($sformatf("%s idle ready d%0d", tag, d), lr[d], 1'b1);
        chk($sformatf("%s idle busy d%0d", tag, d), bz[d], 1'b0);
        chk($sformatf("%s idle line d%0d", tag, d), so[d], 1'b1);
        chk($sformatf("%s idle valid d%0d", tag, d), sv[d], 1'b0);
        chk($sformatf("%s idle done d%0d", tag, d), dn[d], 1'b0);
    endtask

    task automatic accept(input int d, input logic [7:0] w);
        @(negedge clk);
        din[d] = w;
        lv[d]  = 1'b1;
        @(posedge clk);
        #1;
        lv[d]  = 1'b0;
    endtask

    // Called 1 time unit after the accept edge; walks the frame in exp_q and
    // finishes 1 time unit after the edge that returns to idle
    task automatic check_frame(input int d, input bit pulse, input string tag);
        int bc;
        int len;
        int b;
        bc  = bc_of(d);
        len = exp_q.size() * bc;
        for (int i = 0; i < len; i++) begin
            b = i / bc;
            chk($sformatf("%s line c%0d", tag, i), so[d], exp_q[b]);
            chk($sformatf("%s valid c%0d", tag, i), sv[d],
                ss_of(d) ? ((b >= 1 && b <= 8) ? 1'b1 : 1'b0) : 1'b1);
            chk($sformatf("%s busy c%0d", tag, i), bz[d], 1'b1);
            chk($sformatf("%s ready c%0d", tag, i), lr[d], 1'b0);
            chk($sformatf("%s done c%0d", tag, i), dn[d], (i == len - 1) ? 1'b1 : 1'b0);
            if (pulse && i == len / 2) begin
                din[d] = 8'hFF;
                lv[d]  = 1'b1;
            end else if (pulse && i == len / 2 + 1) begin
                lv[d]  = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk_idle(d, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish first");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din[d] = 8'h00;
            lv[d]  = 1'b0;
        end

        vecs[0] = '{0, 8'hA5, 16'b0101001011, 10, 1'b0};
        vecs[1] = '{1, 8'h01, 16'b0100000001, 10, 1'b0};
        vecs[2] = '{0, 8'h3C, 16'b0001111001, 10, 1'b1};
        vecs[3] = '{1, 8'hC8, 16'b0000100111, 10, 1'b1};
        vecs[4] = '{2, 8'hC3, 16'b11000011,    8, 1'b0};

        // Reset held two cycles with a word offered: nothing may start
        @(negedge clk);
        lv[0]  = 1'b1;
        din[0] = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk_idle(0, "reset");
        end
        @(negedge clk);
        rst   = 1'b0;
        lv[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_idle(d, "postreset");

        // Directed frames from the table
        for (int v = 0; v < 5; v++) begin
            accept(vecs[v].dut, vecs[v].word);
            table_bits(vecs[v].bits, vecs[v].nbits);
            check_frame(vecs[v].dut, vecs[v].pulse, $sformatf("vec%0d", v));
        end

        // Reset during data bit 3 of 8'hF0 aborts the frame silently
        accept(0, 8'hF0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort bit3 line", so[0], 1'b1);
        chk("abort bit3 valid", sv[0], 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort no done c%0d", i), dn[0], 1'b0);
            chk($sformatf("abort no busy c%0d", i), bz[0], 1'b0);
        end
        accept(0, 8'h81);
        model_bits(0, 8'h81);
        check_frame(0, 1'b0, "after_abort");

        // Unframed back-to-back: load_valid held high across two words
        @(negedge clk);
        din[2] = 8'hC3;
        lv[2]  = 1'b1;
        @(posedge clk);
        #1;
        din[2] = 8'h5A;
        model_bits(2, 8'hC3);
        check_frame(2, 1'b0, "b2b_first");
        @(posedge clk);
        #1;
        lv[2] = 1'b0;
        model_bits(2, 8'h5A);
        check_frame(2, 1'b0, "b2b_second");

        // Randomized words, instances, mid-frame pulses and idle gaps
        for (int r = 0; r < 40; r++) begin
            int         d;
            logic [7:0] w;
            bit         p;
            int         gap;
            d   = $urandom_range(0, 2);
            w   = 8'($urandom);
            p   = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                chk_idle(d, $sformatf("rnd%0d gap", r));
            end
            accept(d, w);
            model_bits(d, w);
            check_frame(d, p, $sformatf("rnd%0d w%02h", r, w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_serial_tx
`default_nettype wire
